var_state_loader: RTL



---
 rtl/var_state_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/var_state_loader.sv
// var_state_loader: moves per-variable state words between a bin's local
// state memory and the engine's var_state array.
//   LOAD : reads NUM_VARS words from memory (base + k) and writes each one,
//          a cycle later, into the engine through a one-hot wr_states slot.
//   STORE: snapshots the engine's state bus on the start edge, then writes
//          the snapshot to memory one word per cycle.
// Start handshake: start_load_i / start_store_i are single-cycle pulses,
// accepted only in IDLE or DONE (busy_o=0); store wins when both are high;
// pulses arriving while busy_o=1 are dropped. done_o pulses once per
// accepted operation, never after a reset abort.
module var_state_loader #(
  parameter int NUM_VARS         = 8,
  parameter int WIDTH_VAR_STATES = 19,
  parameter int WIDTH_ADDR       = 10,
  parameter int WIDTH_CNT        = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_load_i,
  input  logic                                 start_store_i,
  input  logic [WIDTH_ADDR-1:0]                base_addr_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 mem_rd_en_o,
  output logic                                 mem_wr_en_o,
  output logic [WIDTH_ADDR-1:0]                mem_addr_o,
  output logic [WIDTH_VAR_STATES-1:0]          mem_wdata_o,
  input  logic [WIDTH_VAR_STATES-1:0]          mem_rdata_i,
  output logic [NUM_VARS-1:0]                  wr_states_o,
  output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o,
  input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_RD    = 3'd1,
    LD_DRAIN = 3'd2,
    ST_WR    = 3'd3,
    DONE     = 3'd4
  } state_e;

  localparam logic [WIDTH_CNT-1:0] LAST_IDX = WIDTH_CNT'(NUM_VARS - 1);

  state_e                              state_q, state_d;
  logic [WIDTH_CNT-1:0]                cnt_q, cnt_d;
  logic [WIDTH_ADDR-1:0]               base_q, base_d;
  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] snap_q, snap_d;
  // Load write-back lags the read by one cycle: remember that a read was
  // issued last cycle and for which variable.
  logic                                ld_wr_q, ld_wr_d;
  logic [WIDTH_CNT-1:0]                ld_idx_q, ld_idx_d;

  // State, counter, base, snapshot and write-back registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      base_q   <= '0;
      snap_q   <= '0;
      ld_wr_q  <= 1'b0;
      ld_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      snap_q   <= snap_d;
      ld_wr_q  <= ld_wr_d;
      ld_idx_q <= ld_idx_d;
    end
  end

  // Next-state logic; IDLE and DONE both accept a new start so back-to-back
  // operations have no extra bubble.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    snap_d   = snap_q;
    ld_wr_d  = (state_q == LD_RD);
    ld_idx_d = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_store_i) begin
          state_d = ST_WR;
          base_d  = base_addr_i;
          cnt_d   = '0;
          snap_d  = vars_states_i;
        end else if (start_load_i) begin
          state_d = LD_RD;
          base_d  = base_addr_i;
          cnt_d   = '0;
        end
      end
      LD_RD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = LD_DRAIN;
      end
      LD_DRAIN: state_d = DONE;
      ST_WR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: memory strobes/address from state and counter, engine
  // write slot from the delayed load index.
  always_comb begin
    busy_o        = (state_q == LD_RD) || (state_q == LD_DRAIN) || (state_q == ST_WR);
    done_o        = (state_q == DONE);
    mem_rd_en_o   = (state_q == LD_RD);
    mem_wr_en_o   = (state_q == ST_WR);
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    wr_states_o   = '0;
    vars_states_o = '0;
    if ((state_q == LD_RD) || (state_q == ST_WR)) begin
      mem_addr_o = base_q + WIDTH_ADDR'(cnt_q);
    end
    for (int k = 0; k < NUM_VARS; k++) begin
      // Variable 0 lives in the most significant slice / enable bit.
      if ((state_q == ST_WR) && (cnt_q == WIDTH_CNT'(k))) begin
        mem_wdata_o = snap_q[WIDTH_VAR_STATES*(NUM_VARS-1-k) +: WIDTH_VAR_STATES];
      end
      if (ld_wr_q && (ld_idx_q == WIDTH_CNT'(k))) begin
        wr_states_o[NUM_VARS-1-k] = 1'b1;
        vars_states_o[WIDTH_VAR_STATES*(NUM_VARS-1-k) +: WIDTH_VAR_STATES] = mem_rdata_i;
      end
    end
  end

endmodule
